mem_access_stage: RTL and testbench

- MEM stage of the 64-bit RISC-V pipeline.
- Sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It consumes the EX/MEM outputs and produces RegWrite, MemtoReg, ReadData, ALU_result and rd for MEM/WB.
- Drives a req/ack data-memory port with variable latency.
- Holds the pipeline with mem_stall while an access is outstanding, and aborts an access after a bus timeout.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/load_extend.sv | 27 ++
 rtl/mem_access_stage.sv | 158 +++++++++++++++
 tb/tb_mem_access_stage.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: funct3 access codes, FSM states and
// lane-mask helpers used by mem_access_stage and load_extend.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {IDLE, REQ, RESP} mem_state_e;

  // Byte-lane mask for an access of the given size, anchored at lane 0.
  function automatic logic [7:0] size_mask(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: size_mask = 8'h01;
      F3_H, F3_HU: size_mask = 8'h03;
      F3_W, F3_WU: size_mask = 8'h0F;
      default:     size_mask = 8'hFF;
    endcase
  endfunction

  // Offset bits that may be nonzero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: align_mask = 3'b111;
      F3_H, F3_HU: align_mask = 3'b110;
      F3_W, F3_WU: align_mask = 3'b100;
      default:     align_mask = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Extracts the addressed bytes from a 64-bit memory word and sign- or
// zero-extends them according to funct3. Purely combinational.
module load_extend
  import mem_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  offset,
  input  logic [2:0]  funct3,
  output logic [63:0] result
);

  logic [63:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (funct3)
      F3_B:    result = {{56{shifted[7]}},  shifted[7:0]};
      F3_H:    result = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:    result = {{32{shifted[31]}}, shifted[31:0]};
      F3_BU:   result = {56'd0, shifted[7:0]};
      F3_HU:   result = {48'd0, shifted[15:0]};
      F3_WU:   result = {32'd0, shifted[31:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the RV64 pipeline: req/ack data-memory port with stall and bus timeout.
// Build option: define MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them down.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic [2:0]  funct3,
  input  logic [63:0] ALU_result,
  input  logic [63:0] WriteData,
  input  logic [4:0]  rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic [63:0] ReadData,
  output logic [63:0] ALU_result_out,
  output logic [4:0]  rd_out,
  output logic        mem_stall,
  output logic        bus_err,
  output logic        misalign_exc
);

  mem_state_e      state;
  logic [TO_W-1:0] to_cnt;
  logic [63:0]     rdata_q;
  logic            aborted;
  logic [2:0]      f3_q;
  logic [2:0]      off_q;

  logic            mem_op;
  logic            issue;
  logic [2:0]      off;
  logic [7:0]      smask;
  logic [63:0]     wdata_rep;
  logic [63:0]     load_val;

  assign mem_op = ex_valid & (MemRead | MemWrite);
  assign smask  = size_mask(funct3);
  assign off    = ALU_result[2:0] & align_mask(funct3);

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned   = |(ALU_result[2:0] & ~align_mask(funct3));
  assign misalign_exc = (state == IDLE) & mem_op & misaligned;
  assign issue        = (state == IDLE) & mem_op & ~misaligned;
`else
  assign misalign_exc = 1'b0;
  assign issue        = (state == IDLE) & mem_op;
`endif

  always_comb begin
    case (funct3[1:0])
      2'b00:   wdata_rep = {8{WriteData[7:0]}};
      2'b01:   wdata_rep = {4{WriteData[15:0]}};
      2'b10:   wdata_rep = {2{WriteData[31:0]}};
      default: wdata_rep = WriteData;
    endcase
  end

  // Extraction uses the size/offset latched at issue, not the live EX/MEM fields.
  load_extend u_load_extend (
    .rdata  (mem_rdata),
    .offset (off_q),
    .funct3 (f3_q),
    .result (load_val)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      to_cnt    <= '0;
      rdata_q   <= '0;
      bus_err   <= 1'b0;
      aborted   <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            state     <= REQ;
            mem_req   <= 1'b1;
            mem_we    <= MemWrite;
            mem_addr  <= {ALU_result[63:3], 3'b000};
            mem_wdata <= wdata_rep;
            mem_wstrb <= smask << off;
            to_cnt    <= '0;
            aborted   <= 1'b0;
            f3_q      <= funct3;
            off_q     <= off;
          end
        end
        REQ: begin
          if (mem_ack) begin
            rdata_q <= mem_we ? 64'd0 : load_val;
            mem_req <= 1'b0;
            to_cnt  <= '0;
            state   <= RESP;
          end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            rdata_q <= '0;
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            aborted <= 1'b1;
            to_cnt  <= '0;
            state   <= RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_stall    = 1'b0;
    ReadData     = '0;
    RegWrite_out = 1'b0;
    case (state)
      IDLE: begin
        mem_stall    = issue;
        RegWrite_out = RegWrite & ex_valid & ~mem_op;
      end
      REQ:  mem_stall = 1'b1;
      RESP: begin
        ReadData     = rdata_q;
        RegWrite_out = RegWrite & ~aborted;
      end
      default: mem_stall = 1'b0;
    endcase
  end

  assign MemtoReg_out   = MemtoReg;
  assign ALU_result_out = ALU_result;
  assign rd_out         = rd;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (timeout shortened to 4 cycles).
module tb_mem_access_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, MemRead, MemWrite, RegWrite, MemtoReg;
  logic [2:0]  funct3;
  logic [63:0] ALU_result, WriteData;
  logic [4:0]  rd;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wstrb;
  logic [63:0] mem_rdata;
  logic        mem_ack;
  logic        RegWrite_out, MemtoReg_out;
  logic [63:0] ReadData, ALU_result_out;
  logic [4:0]  rd_out;
  logic        mem_stall, bus_err, misalign_exc;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .funct3(funct3), .ALU_result(ALU_result), .WriteData(WriteData), .rd(rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
    .ReadData(ReadData), .ALU_result_out(ALU_result_out), .rd_out(rd_out),
    .mem_stall(mem_stall), .bus_err(bus_err), .misalign_exc(misalign_exc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic mr, input logic mw, input logic rw,
                       input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wd, input logic [4:0] rd_i);
    ex_valid   = v;
    MemRead    = mr;
    MemWrite   = mw;
    RegWrite   = rw;
    MemtoReg   = mr;
    funct3     = f3;
    ALU_result = addr;
    WriteData  = wd;
    rd         = rd_i;
  endtask

  task automatic idle();
    ex_valid = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  // Runs one stalled access from its IDLE cycle to its RESP cycle; ack_at is the
  // mem_req cycle (1-based) carrying mem_ack, 0 means never acknowledge.
  task automatic run_access(input int ack_at, input logic [63:0] rd_val,
                            output int stall_n, output int req_n,
                            output logic [63:0] a0, output logic [7:0] s0,
                            output logic [63:0] w0, output logic we0,
                            output logic stable, output logic [63:0] rdat,
                            output logic rw, output logic be);
    int   cyc;
    logic was_stall;
    stall_n = 0; req_n = 0; stable = 1'b1;
    a0 = '0; s0 = '0; w0 = '0; we0 = 1'b0;
    was_stall = 1'b0; cyc = 0;
    mem_rdata = rd_val;
    #1;
    while (!(was_stall && !mem_stall) && cyc < 40) begin
      if (mem_stall) stall_n++;
      was_stall = was_stall | mem_stall;
      if (mem_req) begin
        req_n++;
        if (req_n == 1) begin
          a0 = mem_addr; s0 = mem_wstrb; w0 = mem_wdata; we0 = mem_we;
        end else if (mem_addr !== a0 || mem_wstrb !== s0 || mem_wdata !== w0 || mem_we !== we0) begin
          stable = 1'b0;
        end
      end
      mem_ack = (ack_at != 0) && mem_req && (req_n == ack_at);
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      cyc++;
    end
    check("resp_reached_in_budget", 64'(cyc < 40), 64'd1);
    rdat = ReadData;
    rw   = RegWrite_out;
    be   = bus_err;
  endtask

  int          sn, rn;
  logic [63:0] a0, w0, rdat;
  logic [7:0]  s0;
  logic        we0, stb, rw, be;

  initial begin
    reset = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    drive(0, 0, 0, 0, F3_B, 64'd0, 64'd0, 5'd0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_bus_err", 64'(bus_err), 64'd0);
    check("rst_stall", 64'(mem_stall), 64'd0);
    check("rst_readdata", ReadData, 64'd0);
    reset = 1'b1;

    // ALU op passthrough
    @(negedge clk);
    drive(1, 0, 0, 1, F3_D, 64'h1234, 64'd0, 5'd5);
    MemtoReg = 1'b1;
    #1;
    check("alu_regwrite", 64'(RegWrite_out), 64'd1);
    check("alu_result_out", ALU_result_out, 64'h1234);
    check("alu_rd_out", 64'(rd_out), 64'd5);
    check("alu_memtoreg_out", 64'(MemtoReg_out), 64'd1);
    check("alu_stall", 64'(mem_stall), 64'd0);
    check("alu_readdata", ReadData, 64'd0);
    @(negedge clk); #1;
    check("alu_no_req", 64'(mem_req), 64'd0);

    // Load with ex_valid low is ignored
    drive(0, 1, 0, 1, F3_W, 64'h1004, 64'd0, 5'd6);
    #1;
    check("inv_stall", 64'(mem_stall), 64'd0);
    check("inv_regwrite", 64'(RegWrite_out), 64'd0);
    @(negedge clk); #1;
    check("inv_no_req", 64'(mem_req), 64'd0);

    // LW 0x1004, ack on first request cycle
    drive(1, 1, 0, 1, F3_W, 64'h1004, 64'd0, 5'd7);
    run_access(1, 64'h8000_0000_0000_0000, sn, rn, a0, s0, w0, we0, stb, rdat, rw, be);
    idle();
    check("lw_addr", a0, 64'h1000);
    check("lw_we", 64'(we0), 64'd0);
    check("lw_stall_cycles", 64'(sn), 64'd2);
    check("lw_readdata", rdat, 64'hFFFF_FFFF_8000_0000);
    check("lw_regwrite", 64'(rw), 64'd1);

    // LWU, same stimulus
    @(negedge clk);
    drive(1, 1, 0, 1, F3_WU, 64'h1004, 64'd0, 5'd7);
    run_access(1, 64'h8000_0000_0000_0000, sn, rn, a0, s0, w0, we0, stb, rdat, rw, be);
    idle();
    check("lwu_readdata", rdat, 64'h0000_0000_8000_0000);
    check("lwu_stall_cycles", 64'(sn), 64'd2);

    // LH 0x1006, ack on second request cycle
    @(negedge clk);
    drive(1, 1, 0, 1, F3_H, 64'h1006, 64'd0, 5'd8);
    run_access(2, 64'hFFFE_0000_0000_0000, sn, rn, a0, s0, w0, we0, stb, rdat, rw, be);
    idle();
    check("lh_readdata", rdat, 64'hFFFF_FFFF_FFFF_FFFE);
    check("lh_stall_cycles", 64'(sn), 64'd3);
    check("lh_wstrb", 64'(s0), 64'hC0);

    // LD 0x3000 never acknowledged: timeout abort
    @(negedge clk);
    drive(1, 1, 0, 1, F3_D, 64'h3000, 64'd0, 5'd9);
    run_access(0, 64'hDEAD_BEEF_0000_0001, sn, rn, a0, s0, w0, we0, stb, rdat, rw, be);
    idle();
    check("to_req_cycles", 64'(rn), 64'd4);
    check("to_stall_cycles", 64'(sn), 64'd5);
    check("to_bus_err_pulse", 64'(be), 64'd1);
    check("to_regwrite", 64'(rw), 64'd0);
    check("to_readdata", rdat, 64'd0);
    check("to_req_stable", 64'(stb), 64'd1);
    @(negedge clk); #1;
    check("to_bus_err_clear", 64'(bus_err), 64'd0);
    check("to_req_low", 64'(mem_req), 64'd0);

    // SB 0x2003, ack on third request cycle
    drive(1, 0, 1, 0, F3_B, 64'h2003, 64'hAB, 5'd0);
    run_access(3, 64'd0, sn, rn, a0, s0, w0, we0, stb, rdat, rw, be);
    idle();
    check("sb_wstrb", 64'(s0), 64'h08);
    check("sb_wdata", w0, 64'hABAB_ABAB_ABAB_ABAB);
    check("sb_we", 64'(we0), 64'd1);
    check("sb_addr", a0, 64'h2000);
    check("sb_stall_cycles", 64'(sn), 64'd4);
    check("sb_regwrite", 64'(rw), 64'd0);
    check("sb_req_stable", 64'(stb), 64'd1);

    // SW 0x4004
    @(negedge clk);
    drive(1, 0, 1, 0, F3_W, 64'h4004, 64'h1122_3344_5566_7788, 5'd0);
    run_access(1, 64'd0, sn, rn, a0, s0, w0, we0, stb, rdat, rw, be);
    idle();
    check("sw_wstrb", 64'(s0), 64'hF0);
    check("sw_wdata", w0, 64'h5566_7788_5566_7788);

    // SD 0x4000
    @(negedge clk);
    drive(1, 0, 1, 0, F3_D, 64'h4000, 64'h1122_3344_5566_7788, 5'd0);
    run_access(1, 64'd0, sn, rn, a0, s0, w0, we0, stb, rdat, rw, be);
    idle();
    check("sd_wstrb", 64'(s0), 64'hFF);
    check("sd_wdata", w0, 64'h1122_3344_5566_7788);

    // MemRead and MemWrite both set behaves as a store
    @(negedge clk);
    drive(1, 1, 1, 0, F3_W, 64'h6008, 64'h1122_3344, 5'd0);
    run_access(1, 64'd0, sn, rn, a0, s0, w0, we0, stb, rdat, rw, be);
    idle();
    check("rw_both_we", 64'(we0), 64'd1);
    check("rw_both_wstrb", 64'(s0), 64'h0F);
    check("rw_both_addr", a0, 64'h6008);

`ifdef MISALIGN_TRAP_EN
    @(negedge clk);
    drive(1, 1, 0, 1, F3_H, 64'h1001, 64'd0, 5'd3);
    #1;
    check("mis_exc", 64'(misalign_exc), 64'd1);
    check("mis_stall", 64'(mem_stall), 64'd0);
    check("mis_regwrite", 64'(RegWrite_out), 64'd0);
    @(negedge clk); #1;
    check("mis_no_req", 64'(mem_req), 64'd0);
    idle();
`else
    @(negedge clk);
    drive(1, 1, 0, 1, F3_H, 64'h1001, 64'd0, 5'd3);
    #1;
    check("mis_exc_tied", 64'(misalign_exc), 64'd0);
    run_access(1, 64'hFFFF_FFFF_FFFF_1234, sn, rn, a0, s0, w0, we0, stb, rdat, rw, be);
    idle();
    check("mis_lh_addr", a0, 64'h1000);
    check("mis_lh_readdata", rdat, 64'h1234);
    @(negedge clk);
    drive(1, 0, 1, 0, F3_H, 64'h1001, 64'h5678, 5'd0);
    run_access(1, 64'd0, sn, rn, a0, s0, w0, we0, stb, rdat, rw, be);
    idle();
    check("mis_sh_wstrb", 64'(s0), 64'h03);
    check("mis_sh_wdata", w0, 64'h5678_5678_5678_5678);
`endif

    // Reset asserted for one edge while in REQ
    @(negedge clk);
    drive(1, 1, 0, 1, F3_D, 64'h5000, 64'd0, 5'd4);
    mem_rdata = 64'h0123_4567_89AB_CDEF;
    @(negedge clk); #1;
    check("rreq_req_before", 64'(mem_req), 64'd1);
    reset = 1'b0;
    ex_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rreq_req_dropped", 64'(mem_req), 64'd0);
    check("rreq_stall", 64'(mem_stall), 64'd0);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("rreq_stray_ack_regwrite", 64'(RegWrite_out), 64'd0);
    check("rreq_stray_ack_readdata", ReadData, 64'd0);
    check("rreq_stray_ack_req", 64'(mem_req), 64'd0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
